ps2_cmd_sequencer: RTL

PS2_CMD_SEQUENCER -- requirements
Module: ps2_cmd_sequencer

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_timeout_counter.sv | 30 +++
 rtl/ps2_cmd_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 host command sequencer: device reply codes,
// error encodings and the FSM state type.
package ps2_pkg;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RETRIES = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_TX  = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

endpackage

// File: rtl/ps2_timeout_counter.sv
// Saturating cycle counter that flags expiry on its last count while enabled.
module ps2_timeout_counter #(
  parameter int CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_count;

  // Saturate at LAST so a deferred expiry stays asserted instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Sends a PS/2 command (and optional argument) to the device, handling
// ACK / RESEND replies, bounded resends and a reply timeout.
module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT_CYCLES = 2000000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] tx_byte,
  output logic       tx_wr,
  input  logic       tx_idle,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_done
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  state_t        r_state, w_state_next;
  logic [7:0]    r_cmd, w_cmd_next;
  logic [7:0]    r_arg, w_arg_next;
  logic          r_has_arg, w_has_arg_next;
  logic          r_phase, w_phase_next;
  logic [RW-1:0] r_retry, w_retry_next;
  logic [1:0]    r_err_code, w_err_code_next;
  logic          r_cmd_done, w_cmd_done_next;
  logic          r_cmd_err, w_cmd_err_next;
  logic          w_tx_wr;
  logic          w_timer_en;
  logic          w_expired;
  logic          w_ready;

  // Not ready during the completion pulse, so a new accept never overlaps it.
  assign w_ready    = (r_state == IDLE) && !r_cmd_done && !r_cmd_err;
  assign w_timer_en = (r_state == WAIT_TX) || (r_state == WAIT_ACK);

  ps2_timeout_counter #(
    .CYCLES(ACK_TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_tx_wr),
    .enable (w_timer_en),
    .expired(w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_arg      <= '0;
      r_has_arg  <= 1'b0;
      r_phase    <= 1'b0;
      r_retry    <= '0;
      r_err_code <= ERR_NONE;
      r_cmd_done <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cmd      <= w_cmd_next;
      r_arg      <= w_arg_next;
      r_has_arg  <= w_has_arg_next;
      r_phase    <= w_phase_next;
      r_retry    <= w_retry_next;
      r_err_code <= w_err_code_next;
      r_cmd_done <= w_cmd_done_next;
      r_cmd_err  <= w_cmd_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cmd_next      = r_cmd;
    w_arg_next      = r_arg;
    w_has_arg_next  = r_has_arg;
    w_phase_next    = r_phase;
    w_retry_next    = r_retry;
    w_err_code_next = r_err_code;
    w_cmd_done_next = 1'b0;
    w_cmd_err_next  = 1'b0;
    w_tx_wr         = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && w_ready) begin
          w_cmd_next      = cmd_byte;
          w_arg_next      = cmd_arg;
          w_has_arg_next  = cmd_has_arg;
          w_phase_next    = 1'b0;
          w_retry_next    = '0;
          w_err_code_next = ERR_NONE;
          w_state_next    = SEND;
        end
      end
      SEND: begin
        if (tx_idle) begin
          w_tx_wr      = 1'b1;
          w_state_next = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (tx_done) begin
          w_state_next = WAIT_ACK;
        end else if (w_expired) begin
          w_cmd_err_next  = 1'b1;
          w_err_code_next = ERR_TIMEOUT;
          w_state_next    = IDLE;
        end
      end
      WAIT_ACK: begin
        // Any received byte outranks a simultaneous expiry; the saturated
        // counter re-fires on the next cycle if the byte was not a reply.
        if (rx_done) begin
          if (rx_data == PS2_ACK) begin
            if (!r_phase && r_has_arg) begin
              w_phase_next = 1'b1;
              w_retry_next = '0;
              w_state_next = SEND;
            end else begin
              w_cmd_done_next = 1'b1;
              w_state_next    = IDLE;
            end
          end else if (rx_data == PS2_RESEND) begin
            if (r_retry < RETRY_LIMIT) begin
              w_retry_next = r_retry + 1'b1;
              w_state_next = SEND;
            end else begin
              w_cmd_err_next  = 1'b1;
              w_err_code_next = ERR_RETRIES;
              w_state_next    = IDLE;
            end
          end
        end else if (w_expired) begin
          w_cmd_err_next  = 1'b1;
          w_err_code_next = ERR_TIMEOUT;
          w_state_next    = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign cmd_ready = w_ready;
  assign busy      = (r_state != IDLE);
  assign tx_byte   = r_phase ? r_arg : r_cmd;
  assign tx_wr     = w_tx_wr;
  assign cmd_done  = r_cmd_done;
  assign cmd_err   = r_cmd_err;
  assign err_code  = r_err_code;

endmodule
